// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command codes, SCL timing states and bit-period constants.
// Used by the SCL timing stage and the SDA sequencer.
package i2c_pkg;

   localparam int unsigned PHASE_W = 5;
   localparam int unsigned BIT_W   = 4;

   localparam int unsigned I2C_PHASES       = 8;
   localparam int unsigned I2C_ACK_BIT      = 8;
   localparam int unsigned I2C_LAUNCH_PHASE = 1;
   localparam int unsigned I2C_SAMPLE_PHASE = 5;
   localparam int unsigned I2C_HIGH_PHASE   = 4;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_BYTE  = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_WAIT,
      ST_RSTART,
      ST_STOP,
      ST_BUSFREE
   } scl_state_t;

endpackage

// File: rtl/i2c_prescaler.sv
// Phase-tick prescaler: counts 0..CLK_DIV-1 and flags the cycle whose edge advances the phase.
// tick is registered from the next count so it is high while the count sits at its terminal value.
module i2c_prescaler #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic hold,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Next count: clear wins, hold freezes, otherwise wrap at the terminal count.
   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = '0;
      else if (hold)
         cnt_nxt = cnt;
      else if (cnt == TERM)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + CNT_W'(1);
   end

   // Count register and terminal-count flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (cnt_nxt == TERM);
      end
   end

endmodule

// File: rtl/i2c_scl_timing.sv
// I2C master SCL timing stage: SCL waveform, bit phase and bit index for the SDA sequencer.
// Build option: define I2C_SCL_STRETCH_EN to honour slave clock stretching at phase 4.
module i2c_scl_timing
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic [1:0]         cmd,
   output logic               cmd_ready,
   inout  wire                scl_m,
   output logic [PHASE_W-1:0] phase,
   output logic [BIT_W-1:0]   bit_idx,
   output logic               tick,
   output logic               byte_done,
   output logic               stop_done,
   output logic               cmd_err,
   output logic               busy
);

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(I2C_PHASES - 1);
   localparam logic [PHASE_W-1:0] HIGH_PHASE = PHASE_W'(I2C_HIGH_PHASE);
   localparam logic [BIT_W-1:0]   ACK_BIT    = BIT_W'(I2C_ACK_BIT);

   scl_state_t state;
   logic       scl_low;
   logic       adv;
   logic       hold;
   logic       clear;
   logic       accept;
   logic       clocked;

   assign accept  = cmd_valid && cmd_ready;
   assign clear   = (state == ST_IDLE) || (state == ST_WAIT);
   assign clocked = (state == ST_BIT) || (state == ST_RSTART) || (state == ST_STOP);

   // Open drain: only ever pull low; reset releases the line at once.
   assign scl_m = scl_low ? 1'b0 : 1'bz;

`ifdef I2C_SCL_STRETCH_EN
   logic [1:0] scl_sync;
   logic       high_seen;

   // Synchronise SCL readback and note when the high half has really started.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync  <= 2'b11;
         high_seen <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[0], scl_m};
         if (adv)
            high_seen <= 1'b0;
         else if (phase == HIGH_PHASE && scl_sync[1])
            high_seen <= 1'b1;
      end
   end

   assign hold = clocked && (phase == HIGH_PHASE) && !scl_sync[1] && !high_seen;
`else
   assign hold = 1'b0;
`endif

   i2c_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .hold  (hold),
      .clear (clear),
      .tick  (adv)
   );

   // Bus-timing FSM with registered SCL drive, counters and strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         phase     <= '0;
         bit_idx   <= '0;
         scl_low   <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         tick      <= 1'b0;
         byte_done <= 1'b0;
         stop_done <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         tick      <= adv;
         byte_done <= 1'b0;
         stop_done <= 1'b0;
         cmd_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               phase     <= '0;
               bit_idx   <= '0;
               cmd_ready <= 1'b1;
               if (accept) begin
                  if (cmd == CMD_START) begin
                     state     <= ST_START;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                  end else if (cmd != CMD_NONE) begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               phase     <= '0;
               cmd_ready <= 1'b1;
               if (accept) begin
                  case (cmd)
                     CMD_BYTE: begin
                        state     <= ST_BIT;
                        cmd_ready <= 1'b0;
                     end
                     CMD_STOP: begin
                        state     <= ST_STOP;
                        cmd_ready <= 1'b0;
                     end
                     CMD_START: begin
                        state     <= ST_RSTART;
                        cmd_ready <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               cmd_ready <= 1'b0;
               if (adv) begin
                  if (phase == LAST_PHASE) begin
                     phase <= '0;
                     case (state)
                        ST_START: begin
                           state   <= ST_BIT;
                           bit_idx <= '0;
                           scl_low <= 1'b1;
                        end
                        ST_BIT: begin
                           scl_low <= 1'b1;
                           if (bit_idx == ACK_BIT) begin
                              bit_idx   <= '0;
                              byte_done <= 1'b1;
                              state     <= ST_WAIT;
                           end else begin
                              bit_idx <= bit_idx + BIT_W'(1);
                           end
                        end
                        ST_RSTART: begin
                           state   <= ST_START;
                           scl_low <= 1'b0;
                        end
                        ST_STOP: begin
                           state   <= ST_BUSFREE;
                           scl_low <= 1'b0;
                        end
                        default: begin
                           state     <= ST_IDLE;
                           busy      <= 1'b0;
                           stop_done <= (state == ST_BUSFREE);
                           scl_low   <= 1'b0;
                        end
                     endcase
                  end else begin
                     phase   <= phase + PHASE_W'(1);
                     scl_low <= clocked && (phase < PHASE_W'(3));
                  end
               end
            end
         endcase
      end
   end

endmodule
